// File: rtl/irq_prio_ctrl.sv
// irq_prio_ctrl: edge-latched interrupt pending register with enable mask,
// highest-index priority selection and a valid/ack presentation handshake.
module irq_prio_ctrl #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    irq_in,
    input  logic            mask_wr,
    input  logic [N-1:0]    mask_din,
    input  logic            irq_ack,
    output logic            irq_valid,
    output logic [ID_W-1:0] irq_id,
    output logic [N-1:0]    pending,
    output logic            overflow
);
    typedef enum logic {IDLE, PRESENT} state_t;
    state_t          state_q, state_d;
    logic [N-1:0]    irq_q, pending_q, pending_d, mask_q, rise, clr, cand;
    logic [ID_W-1:0] id_q, id_d, sel;
    logic            ovf_q, ovf_d;
    always_comb begin
        rise = irq_in & ~irq_q;
        clr  = '0;
        if (state_q == PRESENT && irq_ack) clr[id_q] = 1'b1;
        // a fresh rise on the line being cleared survives the clear
        pending_d = (pending_q & ~clr) | rise;
        ovf_d     = |(rise & pending_q & ~clr);
        cand      = pending_q & mask_q;
        sel       = '0;
        for (int i = 0; i < N; i++) if (cand[i]) sel = ID_W'(i);
    end
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        if (state_q == IDLE && cand != '0) begin
            state_d = PRESENT;
            id_d    = sel;
        end else if (state_q == PRESENT && irq_ack) begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            irq_q     <= '0;
            pending_q <= '0;
            mask_q    <= '1;
            id_q      <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            irq_q     <= irq_in;
            pending_q <= pending_d;
            mask_q    <= mask_wr ? mask_din : mask_q;
            id_q      <= id_d;
            ovf_q     <= ovf_d;
        end
    end
    assign irq_valid = (state_q == PRESENT);
    assign irq_id    = id_q;
    assign pending   = pending_q;
    assign overflow  = ovf_q;
endmodule
